axis_pattern_source: RTL and testbench

- AXI-Stream master that generates a deterministic incrementing byte sequence with programmable valid-gaps and packet boundaries.
- Sits directly upstream of the stream checker in the DMA test harness and feeds its slave port.
- A single start pulse launches a run of COUNT beats. The block fully honours TREADY backpressure, so downstream stall logic is exercised end to end.

---
 rtl/axis_pattern_source.sv | 188 ++++++++++++++++++
 tb/tb_axis_pattern_source.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_source.sv
// AXI-Stream master emitting an incrementing byte stream with packet TLAST and source-side valid gaps.
// Build option AXIS_SRC_LFSR_STALL_EN swaps periodic gaps for LFSR-scheduled 1-cycle gaps.
module axis_pattern_source #(
   parameter int unsigned COUNT        = 32,
   parameter logic [7:0]  START_VAL    = 8'd0,
   parameter int unsigned PKT_LEN      = 8,
   parameter int unsigned STALL_PERIOD = 6,
   parameter int unsigned STALL_LEN    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        M_AXIS_TVALID,
   output logic [7:0]  M_AXIS_TDATA,
   output logic        M_AXIS_TLAST,
   input  logic        M_AXIS_TREADY,
   output logic        busy,
   output logic        done,
   output logic [31:0] beats_sent
);

   // Valid/ready: a beat moves on a rising edge with TVALID && TREADY; once TVALID
   // is high, TDATA/TLAST are frozen and TVALID stays high until that edge.

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   state_t      state_q, state_d;
   logic        tvalid_q, tvalid_d;
   logic [7:0]  tdata_q, tdata_d;
   logic        tlast_q, tlast_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] beats_q, beats_d;
   logic [31:0] pkt_q, pkt_d;
   logic [31:0] gap_q, gap_d;
   logic [31:0] pkt_nxt;
   logic        hs;
   logic        last_beat;
   logic        gap_take;
   logic [31:0] gap_load;

`ifdef AXIS_SRC_LFSR_STALL_EN
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   logic [7:0] lfsr_q, lfsr_d, lfsr_nxt;

   // Fibonacci LFSR, taps 8,6,5,4; the feedback bit enters at bit 0
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   assign lfsr_nxt = lfsr_step(lfsr_q);
   assign gap_take = lfsr_nxt[0];
   assign gap_load = 32'd1;
`else
   logic [31:0] stall_q, stall_d;

   assign gap_take = (STALL_LEN != 0) && (stall_q == STALL_PERIOD - 1);
   assign gap_load = STALL_LEN;
`endif

   assign hs        = tvalid_q && M_AXIS_TREADY;
   assign last_beat = (beats_q == COUNT - 1);
   assign pkt_nxt   = (pkt_q == PKT_LEN - 1) ? 32'd0 : pkt_q + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (hs) begin
               if (last_beat)     state_d = DONE;
               else if (gap_take) state_d = GAP;
            end
         end
         GAP:  if (gap_q <= 32'd1) state_d = RUN;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      beats_d  = beats_q;
      pkt_d    = pkt_q;
      gap_d    = gap_q;
`ifdef AXIS_SRC_LFSR_STALL_EN
      lfsr_d   = lfsr_q;
`else
      stall_d  = stall_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               tvalid_d = 1'b1;
               tdata_d  = START_VAL;
               tlast_d  = (PKT_LEN == 1) || (COUNT == 1);
               busy_d   = 1'b1;
               beats_d  = 32'd0;
               pkt_d    = 32'd0;
`ifdef AXIS_SRC_LFSR_STALL_EN
               lfsr_d   = LFSR_SEED;
`else
               stall_d  = 32'd0;
`endif
            end
         end
         RUN: begin
            if (hs) begin
               beats_d = beats_q + 32'd1;
               pkt_d   = pkt_nxt;
`ifdef AXIS_SRC_LFSR_STALL_EN
               lfsr_d  = lfsr_nxt;
`else
               stall_d = (stall_q == STALL_PERIOD - 1) ? 32'd0 : stall_q + 32'd1;
`endif
               if (last_beat) begin
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  tdata_d = tdata_q + 8'd1;
                  // TLAST of the upcoming beat: packet end or final beat of the run
                  tlast_d = (pkt_nxt == PKT_LEN - 1) || (beats_q + 32'd1 == COUNT - 1);
                  if (gap_take) begin
                     tvalid_d = 1'b0;
                     gap_d    = gap_load;
                  end
               end
            end
         end
         GAP: begin
            gap_d = gap_q - 32'd1;
            if (gap_q <= 32'd1) tvalid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tvalid_q <= 1'b0;
         tdata_q  <= 8'd0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         beats_q  <= 32'd0;
         pkt_q    <= 32'd0;
         gap_q    <= 32'd0;
`ifdef AXIS_SRC_LFSR_STALL_EN
         lfsr_q   <= LFSR_SEED;
`else
         stall_q  <= 32'd0;
`endif
      end else begin
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         beats_q  <= beats_d;
         pkt_q    <= pkt_d;
         gap_q    <= gap_d;
`ifdef AXIS_SRC_LFSR_STALL_EN
         lfsr_q   <= lfsr_d;
`else
         stall_q  <= stall_d;
`endif
      end
   end

   assign M_AXIS_TVALID = tvalid_q;
   assign M_AXIS_TDATA  = tdata_q;
   assign M_AXIS_TLAST  = tlast_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign beats_sent    = beats_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Bench for axis_pattern_source: three parameterisations driven by randomized TREADY,
// each beat checked against a beat-list reference model (optionally LFSR gap scheduling).
module tb_axis_pattern_source;

   localparam int A_COUNT = 32, A_SVAL = 0,   A_PKT = 8, A_SPER = 6, A_SLEN = 2;
   localparam int B_COUNT = 10, B_SVAL = 250, B_PKT = 8, B_SPER = 6, B_SLEN = 2;
   localparam int C_COUNT = 64, C_SVAL = 0,   C_PKT = 1, C_SPER = 6, C_SLEN = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, tready;
   logic start_a, start_b, start_c;
   logic a_tvalid, b_tvalid, c_tvalid, a_tlast, b_tlast, c_tlast;
   logic a_busy, b_busy, c_busy, a_done, b_done, c_done;
   logic [7:0] a_tdata, b_tdata, c_tdata;
   logic [31:0] a_beats, b_beats, c_beats;

   int vectors = 0;
   int miscompares = 0;

   axis_pattern_source #(.COUNT(A_COUNT), .START_VAL(8'(A_SVAL)), .PKT_LEN(A_PKT),
      .STALL_PERIOD(A_SPER), .STALL_LEN(A_SLEN)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .M_AXIS_TVALID(a_tvalid),
      .M_AXIS_TDATA(a_tdata), .M_AXIS_TLAST(a_tlast), .M_AXIS_TREADY(tready),
      .busy(a_busy), .done(a_done), .beats_sent(a_beats));

   axis_pattern_source #(.COUNT(B_COUNT), .START_VAL(8'(B_SVAL)), .PKT_LEN(B_PKT),
      .STALL_PERIOD(B_SPER), .STALL_LEN(B_SLEN)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .M_AXIS_TVALID(b_tvalid),
      .M_AXIS_TDATA(b_tdata), .M_AXIS_TLAST(b_tlast), .M_AXIS_TREADY(tready),
      .busy(b_busy), .done(b_done), .beats_sent(b_beats));

   axis_pattern_source #(.COUNT(C_COUNT), .START_VAL(8'(C_SVAL)), .PKT_LEN(C_PKT),
      .STALL_PERIOD(C_SPER), .STALL_LEN(C_SLEN)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .M_AXIS_TVALID(c_tvalid),
      .M_AXIS_TDATA(c_tdata), .M_AXIS_TLAST(c_tlast), .M_AXIS_TREADY(tready),
      .busy(c_busy), .done(c_done), .beats_sent(c_beats));

   // Observation mux so one run task serves every instance
   logic [1:0]  sel;
   logic        o_tvalid, o_tlast, o_busy, o_done;
   logic [7:0]  o_tdata;
   logic [31:0] o_beats;

   always_comb begin
      o_tvalid = a_tvalid; o_tdata = a_tdata; o_tlast = a_tlast;
      o_busy   = a_busy;   o_done  = a_done;  o_beats = a_beats;
      case (sel)
         2'd1: begin
            o_tvalid = b_tvalid; o_tdata = b_tdata; o_tlast = b_tlast;
            o_busy   = b_busy;   o_done  = b_done;  o_beats = b_beats;
         end
         2'd2: begin
            o_tvalid = c_tvalid; o_tdata = c_tdata; o_tlast = c_tlast;
            o_busy   = c_busy;   o_done  = c_done;  o_beats = c_beats;
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int s, input logic v);
      case (s)
         1: start_b = v;
         2: start_c = v;
         default: start_a = v;
      endcase
   endtask

   function automatic logic ref_last(input int n, input int count, input int pkt);
      return ((n % pkt) == pkt - 1) || (n == count - 1);
   endfunction

   // Reference LFSR: shift toward MSB, new bit0 = XOR of taps 8,6,5,4
   function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
      int fb;
      fb = (v / 128 + v / 32 + v / 16 + v / 8) % 2;
      return 8'(((v * 2) % 256) + fb);
   endfunction

   // One full run; mode 0: TREADY high, 1: 5 high / 3 low, 2: random
   task automatic run_stream(input int s, input int count, input int sval, input int pkt,
                             input int sper, input int slen, input int mode, input bit noise);
      int idx, gap_left, cyc, ph;
      bit in_gap, rdy;
      logic [7:0] lf;
      sel = 2'(s);
      @(negedge clk);
      set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
      idx = 0; gap_left = 0; cyc = 0; ph = 0; lf = 8'hA5;
      while (ph < 2 && cyc < 4000) begin
         if (ph == 0) begin
            check("busy", o_busy, 1);
            check("beats_sent", o_beats, idx);
            check("done_low", o_done, 0);
            in_gap = (gap_left > 0);
            if (in_gap) begin
               check("tvalid_gap", o_tvalid, 0);
               gap_left--;
            end else begin
               check("tvalid", o_tvalid, 1);
               check("tdata", o_tdata, (sval + idx) % 256);
               check("tlast", o_tlast, ref_last(idx, count, pkt));
            end
            case (mode)
               0: rdy = 1'b1;
               1: rdy = (cyc % 8) < 5;
               default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            tready = rdy;
            if (noise) set_start(s, 1'($urandom_range(0, 1)));
            if (!in_gap && rdy) begin
               idx++;
               lf = ref_lfsr(lf);
               if (idx == count) ph = 1;
`ifdef AXIS_SRC_LFSR_STALL_EN
               else if (lf[0]) gap_left = 1;
`else
               else if (slen > 0 && (idx % sper) == 0) gap_left = slen;
`endif
            end
         end else begin
            check("done_pulse", o_done, 1);
            check("tvalid_done", o_tvalid, 0);
            check("busy_done", o_busy, 0);
            check("beats_final", o_beats, count);
            if (noise) set_start(s, 1'b1);
            ph = 2;
         end
         cyc++;
         @(negedge clk);
      end
      check("run_timeout", ph, 2);
      set_start(s, 1'b0);
      tready = 1'b1;
      check("done_once", o_done, 0);
      check("idle_busy", o_busy, 0);
      check("idle_tvalid", o_tvalid, 0);
      @(negedge clk);
      check("no_restart_tvalid", o_tvalid, 0);
      check("no_restart_busy", o_busy, 0);
   endtask

   initial begin
      int w;
      rst_n = 1'b0; tready = 1'b1; sel = 2'd0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", a_tvalid, 0);
      check("rst_tdata", a_tdata, 0);
      check("rst_tlast", a_tlast, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_beats", a_beats, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_no_start", a_tvalid, 0);

      run_stream(0, A_COUNT, A_SVAL, A_PKT, A_SPER, A_SLEN, 0, 1'b0);
      run_stream(0, A_COUNT, A_SVAL, A_PKT, A_SPER, A_SLEN, 1, 1'b0);
      run_stream(0, A_COUNT, A_SVAL, A_PKT, A_SPER, A_SLEN, 2, 1'b1);

      // Reset in the middle of a run, while beat 12 is being offered
      sel = 2'd0; tready = 1'b1;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      w = 0;
      while (!(a_beats == 32'd12 && a_tvalid) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("rst_wait_timeout", (w < 200) ? 1 : 0, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_tvalid", a_tvalid, 0);
      check("async_beats", a_beats, 0);
      check("async_busy", a_busy, 0);
      check("async_tdata", a_tdata, 0);
      repeat (2) begin
         @(negedge clk);
         check("rst_no_done", a_done, 0);
      end
      rst_n = 1'b1;
      run_stream(0, A_COUNT, A_SVAL, A_PKT, A_SPER, A_SLEN, 0, 1'b0);

      run_stream(1, B_COUNT, B_SVAL, B_PKT, B_SPER, B_SLEN, 2, 1'b0);
      run_stream(1, B_COUNT, B_SVAL, B_PKT, B_SPER, B_SLEN, 0, 1'b0);
      run_stream(2, C_COUNT, C_SVAL, C_PKT, C_SPER, C_SLEN, 2, 1'b1);
      run_stream(2, C_COUNT, C_SVAL, C_PKT, C_SPER, C_SLEN, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
